// File: rtl/ten_gig_eth_pcs_pma_0_sync_filter_bus.sv
// Multi-channel CDC synchroniser with per-channel glitch filter and edge pulses.
// Optional sticky change flag enabled by macro TEN_GIG_SYNC_FILTER_STICKY_EN.
module ten_gig_eth_pcs_pma_0_sync_filter_bus #(
    parameter int unsigned        C_WIDTH         = 4,
    parameter int unsigned        C_NUM_SYNC_REGS = 3,
    parameter logic [C_WIDTH-1:0] C_RVAL          = '0,
    parameter int unsigned        C_FILTER_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [C_WIDTH-1:0] data_in,
    input  logic [C_WIDTH-1:0] clear_sticky,
    output logic [C_WIDTH-1:0] data_out,
    output logic [C_WIDTH-1:0] rise_pulse,
    output logic [C_WIDTH-1:0] fall_pulse,
    output logic [C_WIDTH-1:0] sticky_change
);

    localparam int unsigned     CNT_W    = $clog2(C_FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_FILTER_CYCLES - 1);

    for (genvar gi = 0; gi < C_WIDTH; gi++) begin : g_ch
        (* ASYNC_REG = "TRUE", shreg_extract = "no" *)
        logic [C_NUM_SYNC_REGS-1:0] sync_q;
        logic [C_NUM_SYNC_REGS-1:0] sync_d;
        logic                       sync_out;
        logic [CNT_W-1:0]           cnt_q;
        logic [CNT_W-1:0]           cnt_d;
        logic                       data_q;
        logic                       data_d;
        logic                       rise_q;
        logic                       rise_d;
        logic                       fall_q;
        logic                       fall_d;

        assign sync_d   = {sync_q[C_NUM_SYNC_REGS-2:0], data_in[gi]};
        assign sync_out = sync_q[C_NUM_SYNC_REGS-1];

        // Synchronised value must disagree with data_out for C_FILTER_CYCLES
        // consecutive cycles before it is accepted.
        always_comb begin
            cnt_d  = cnt_q;
            data_d = data_q;
            rise_d = 1'b0;
            fall_d = 1'b0;
            if (sync_out == data_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                data_d = sync_out;
                cnt_d  = '0;
                rise_d = sync_out;
                fall_d = ~sync_out;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= {C_NUM_SYNC_REGS{C_RVAL[gi]}};
                cnt_q  <= '0;
                data_q <= C_RVAL[gi];
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                sync_q <= sync_d;
                cnt_q  <= cnt_d;
                data_q <= data_d;
                rise_q <= rise_d;
                fall_q <= fall_d;
            end
        end

        assign data_out[gi]   = data_q;
        assign rise_pulse[gi] = rise_q;
        assign fall_pulse[gi] = fall_q;

`ifdef TEN_GIG_SYNC_FILTER_STICKY_EN
        logic sticky_q;
        logic sticky_d;

        // A transition on the clear edge wins over the clear.
        assign sticky_d = (sticky_q & ~clear_sticky[gi]) | rise_d | fall_d;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sticky_q <= 1'b0;
            end else begin
                sticky_q <= sticky_d;
            end
        end

        assign sticky_change[gi] = sticky_q;
`endif
    end

`ifndef TEN_GIG_SYNC_FILTER_STICKY_EN
    logic unused_clear;
    assign unused_clear  = ^clear_sticky;
    assign sticky_change = '0;
`endif

endmodule

// File: tb/tb_ten_gig_eth_pcs_pma_0_sync_filter_bus.sv
// Self-checking bench for ten_gig_eth_pcs_pma_0_sync_filter_bus: default, C_RVAL and
// minimum-depth instances, checked against a run-length reference model.
module tb_ten_gig_eth_pcs_pma_0_sync_filter_bus;

    localparam int NS = 3;
    localparam int NF = 4;
`ifdef TEN_GIG_SYNC_FILTER_STICKY_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] din_a, clr_a, out_a, rise_a, fall_a, stk_a;
    logic [3:0] din_r, clr_r, out_r, rise_r, fall_r, stk_r;
    logic [0:0] din_s, clr_s, out_s, rise_s, fall_s, stk_s;
    int total = 0;
    int bad   = 0;

    logic [3:0] m_hist[$];
    logic [3:0] m_old, m_out, m_rise, m_fall, m_stk;
    int         m_run[4];

    always #5 clk = ~clk;

    ten_gig_eth_pcs_pma_0_sync_filter_bus dut_a (
        .clk(clk), .rst_n(rst_n), .data_in(din_a), .clear_sticky(clr_a),
        .data_out(out_a), .rise_pulse(rise_a), .fall_pulse(fall_a), .sticky_change(stk_a));

    ten_gig_eth_pcs_pma_0_sync_filter_bus #(.C_RVAL(4'b1010)) dut_r (
        .clk(clk), .rst_n(rst_n), .data_in(din_r), .clear_sticky(clr_r),
        .data_out(out_r), .rise_pulse(rise_r), .fall_pulse(fall_r), .sticky_change(stk_r));

    ten_gig_eth_pcs_pma_0_sync_filter_bus #(.C_WIDTH(1), .C_NUM_SYNC_REGS(2),
        .C_RVAL(1'b0), .C_FILTER_CYCLES(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .data_in(din_s), .clear_sticky(clr_s),
        .data_out(out_s), .rise_pulse(rise_s), .fall_pulse(fall_s), .sticky_change(stk_s));

    // Reference: sync_out is the input sampled NS edges earlier; data_out flips
    // once sync_out has disagreed with it for NF consecutive edges.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hist.delete();
            for (int k = 0; k < NS; k++) m_hist.push_back(4'b0000);
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            m_out = 4'b0; m_rise = 4'b0; m_fall = 4'b0; m_stk = 4'b0;
        end else begin
            m_old = m_hist.pop_front();
            m_hist.push_back(din_a);
            m_rise = 4'b0;
            m_fall = 4'b0;
            for (int i = 0; i < 4; i++) begin
                if (m_old[i] != m_out[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == NF) begin
                        m_out[i]  = m_old[i];
                        m_rise[i] = m_old[i];
                        m_fall[i] = ~m_old[i];
                        m_run[i]  = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            if (STK) m_stk = (m_stk & ~clr_a) | m_rise | m_fall;
        end
    end

    task automatic cyc(input logic [3:0] d, input logic [3:0] c);
        @(negedge clk);
        din_a = d;
        clr_a = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        din_a = '0; clr_a = '0; din_r = 4'b1010; clr_r = '0; din_s = '0; clr_s = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({out_a, rise_a, fall_a, stk_a} !== 16'h0) begin
            bad++; $display("FAIL reset_a: got %h want 0000", {out_a, rise_a, fall_a, stk_a});
        end
        total++;
        if ({out_r, rise_r, fall_r, stk_r} !== 16'hA000) begin
            bad++; $display("FAIL reset_r: got %h want a000", {out_r, rise_r, fall_r, stk_r});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            cyc(4'b0000, 4'b0000);
            total++;
            if ({out_r, rise_r, fall_r} !== 12'hA00) begin
                bad++; $display("FAIL release_r cyc %0d: got %h want a00", e, {out_r, rise_r, fall_r});
            end
            total++;
            if ({out_a, rise_a, fall_a, stk_a} !== {m_out, m_rise, m_fall, m_stk}) begin
                bad++; $display("FAIL release_a cyc %0d: got %h want %h", e,
                                {out_a, rise_a, fall_a, stk_a}, {m_out, m_rise, m_fall, m_stk});
            end
        end
    endtask

    task automatic test_step();
        logic [3:0] w_out, w_rise;
        for (int e = 1; e <= 8; e++) begin
            cyc(4'b0001, 4'b0000);
            w_out  = (e >= 7) ? 4'b0001 : 4'b0000;
            w_rise = (e == 7) ? 4'b0001 : 4'b0000;
            total++;
            if ({out_a, rise_a, fall_a} !== {w_out, w_rise, 4'b0000}) begin
                bad++; $display("FAIL step edge %0d: got %h want %h", e,
                                {out_a, rise_a, fall_a}, {w_out, w_rise, 4'b0000});
            end
        end
        for (int e = 1; e <= 10; e++) begin
            cyc(4'b0000, 4'b0000);
            total++;
            if ({out_a, rise_a, fall_a, stk_a} !== {m_out, m_rise, m_fall, m_stk}) begin
                bad++; $display("FAIL step_back cyc %0d: got %h want %h", e,
                                {out_a, rise_a, fall_a, stk_a}, {m_out, m_rise, m_fall, m_stk});
            end
        end
    endtask

    task automatic test_glitch();
        int lv[6] = '{1, 0, 1, 0, 1, 0};
        int ln[6] = '{1, 6, 3, 8, 4, 12};
        int n = 0, rises = 0, falls = 0, r_at = -1, f_at = -1;
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < ln[p]; c++) begin
                cyc((lv[p] != 0) ? 4'b0010 : 4'b0000, 4'b0000);
                n++;
                if (rise_a[1]) begin rises++; r_at = n; end
                if (fall_a[1]) begin falls++; f_at = n; end
                total++;
                if ({out_a, rise_a, fall_a, stk_a} !== {m_out, m_rise, m_fall, m_stk}) begin
                    bad++; $display("FAIL glitch cyc %0d: got %h want %h", n,
                                    {out_a, rise_a, fall_a, stk_a}, {m_out, m_rise, m_fall, m_stk});
                end
            end
            if (p == 3) begin
                total++;
                if (rises != 0 || falls != 0 || out_a[1] !== 1'b0) begin
                    bad++; $display("FAIL glitch_short: rises %0d falls %0d out %b want 0 0 0",
                                    rises, falls, out_a[1]);
                end
            end
        end
        total++;
        if (rises != 1 || falls != 1 || (f_at - r_at) != 4) begin
            bad++; $display("FAIL glitch_long: rises %0d falls %0d gap %0d want 1 1 4",
                            rises, falls, f_at - r_at);
        end
    endtask

    task automatic test_reset_mid();
        repeat (10) cyc(4'b0100, 4'b0000);
        total++;
        if (out_a !== 4'b0100) begin
            bad++; $display("FAIL mid_setup: got %b want 0100", out_a);
        end
        repeat (5) cyc(4'b0101, 4'b0000);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({out_a, rise_a, fall_a, stk_a, out_r} !== 20'h0000A) begin
            bad++; $display("FAIL mid_reset: got %h want 0000a", {out_a, rise_a, fall_a, stk_a, out_r});
        end
        repeat (2) cyc(4'b0000, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            cyc(4'b0000, 4'b0000);
            total++;
            if ({out_a, rise_a, fall_a, stk_a} !== 16'h0) begin
                bad++; $display("FAIL mid_release cyc %0d: got %h want 0000", e,
                                {out_a, rise_a, fall_a, stk_a});
            end
        end
    endtask

    task automatic test_sticky();
        logic w;
        for (int e = 1; e <= 12; e++) begin
            cyc(4'b0100, 4'b0000);
            w = STK & (e >= 7);
            total++;
            if ({out_a[2], stk_a} !== {(e >= 7), 1'b0, w, 2'b00}) begin
                bad++; $display("FAIL sticky_set e %0d: got %b %b want %b", e, out_a[2], stk_a, w);
            end
        end
        cyc(4'b0100, 4'b0100);
        total++;
        if (stk_a !== 4'b0000) begin
            bad++; $display("FAIL sticky_clear: got %b want 0000", stk_a);
        end
        for (int e = 1; e <= 7; e++) begin
            cyc(4'b0000, (e == 7) ? 4'b0100 : 4'b0000);
        end
        total++;
        if ({fall_a, stk_a} !== {4'b0100, 1'b0, STK, 2'b00}) begin
            bad++; $display("FAIL sticky_clear_vs_set: got %b %b want 0100 %b", fall_a, stk_a, STK);
        end
    endtask

    task automatic test_random();
        logic [3:0] d, c;
        d = din_a;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 5) == 0) d[i] = ~d[i];
                c[i] = ($urandom_range(0, 3) == 0);
            end
            cyc(d, c);
            total++;
            if ({out_a, rise_a, fall_a, stk_a} !== {m_out, m_rise, m_fall, m_stk}) begin
                bad++; $display("FAIL random cyc %0d: got %h want %h", n,
                                {out_a, rise_a, fall_a, stk_a}, {m_out, m_rise, m_fall, m_stk});
            end
        end
    endtask

    task automatic test_fast();
        @(negedge clk);
        din_s = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            #1;
            total++;
            if ({out_s, rise_s, fall_s} !== {(e >= 3), (e == 3), 1'b0}) begin
                bad++; $display("FAIL fast_rise edge %0d: got %b%b%b", e, out_s, rise_s, fall_s);
            end
        end
        @(negedge clk);
        din_s = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            #1;
            total++;
            if ({out_s, rise_s, fall_s} !== {(e < 3), 1'b0, (e == 3)}) begin
                bad++; $display("FAIL fast_fall edge %0d: got %b%b%b", e, out_s, rise_s, fall_s);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_step();
        test_glitch();
        test_reset_mid();
        test_sticky();
        test_random();
        test_fast();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ten_gig_eth_pcs_pma_0_sync_filter_bus.md
# ten_gig_eth_pcs_pma_0_sync_filter_bus

Multi-channel clock-domain-crossing synchroniser with per-channel glitch filter and edge detection. It replaces single-bit synchroniser instances where several asynchronous status lines (signal detect, PMA lock, fault indications) enter the PCS/PMA core clock domain. Each channel is synchronised through a parameterised flop chain, qualified by a stability counter, and reported as a filtered level plus single-cycle rise and fall pulses, with an optional sticky change flag for management readout.

## Interface
- C_WIDTH, 4: number of independent channels (min 1).
- C_NUM_SYNC_REGS, 3: synchroniser chain depth per channel (min 2).
- C_RVAL, {C_WIDTH{1'b0}}: per-channel reset value of the sync chain and of data_out.
- C_FILTER_CYCLES, 4: consecutive cycles a new synchronised value must persist before data_out follows (min 1).
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset; deassertion is synchronous to clk, provided by the upstream reset synchroniser.
- data_in  in  C_WIDTH  asynchronous channel inputs.
- clear_sticky  in  C_WIDTH  per-channel clear of sticky_change; only used with the macro.
- data_out  out  C_WIDTH  filtered, synchronised levels.
- rise_pulse  out  C_WIDTH  one-cycle pulse when data_out[i] goes 0->1.
- fall_pulse  out  C_WIDTH  one-cycle pulse when data_out[i] goes 1->0.
- sticky_change  out  C_WIDTH  latched "data_out changed" flag; 0 without the macro.

## Operation
- Per channel i: sync chain s_i[0..C_NUM_SYNC_REGS-1], s_i[0] <= data_in[i], s_i[k] <= s_i[k-1]; sync_out_i = s_i[C_NUM_SYNC_REGS-1].
- Sync-chain flops carry ASYNC_REG = "TRUE" and shreg_extract = "no"; no SRL inference.
- Filter counter cnt_i, width clog2(C_FILTER_CYCLES+1), saturating never reached past C_FILTER_CYCLES-1.
- If sync_out_i == data_out[i]: cnt_i <= 0.
- Else if cnt_i == C_FILTER_CYCLES-1: data_out[i] <= sync_out_i, cnt_i <= 0.
- Else cnt_i <= cnt_i + 1.
- A sync_out excursion shorter than C_FILTER_CYCLES cycles returns cnt_i to 0 and never reaches data_out.
- rise_pulse[i]/fall_pulse[i] are registered, asserted on the same edge data_out[i] changes, deasserted next edge; never both high.
- Channels are fully independent; no shared state.
- Reset (rst_n low, any time, including mid-filter): sync chains and data_out = C_RVAL, cnt = 0, rise/fall pulses = 0, sticky_change = 0. No pulse is generated by reset entry or exit.

## Timing
- Edge numbering: data_in[i] settles to new value before edge 1.
- s_i[0] updates at edge 1; sync_out_i at edge C_NUM_SYNC_REGS.
- data_out[i] and pulse update at edge C_NUM_SYNC_REGS + C_FILTER_CYCLES (defaults: edge 7).
- Pulse width exactly 1 cycle; minimum data_out period 2*C_FILTER_CYCLES cycles.
- Input toggling faster than C_FILTER_CYCLES at sync_out: data_out holds indefinitely.
- C_FILTER_CYCLES = 1: behaves as a synchroniser of depth C_NUM_SYNC_REGS+1 with edge pulses.

## Configuration
- Macro TEN_GIG_SYNC_FILTER_STICKY_EN.
- Defined: sticky_change[i] set on any data_out[i] transition (same edge as pulse); cleared on edge where clear_sticky[i] = 1; simultaneous transition and clear -> set wins (stays 1).
- Undefined: sticky_change driven constant 0, clear_sticky ignored, no sticky flops synthesised.

## Test plan
- Reset with C_RVAL = 4'b1010, data_in = 4'b1010, release rst_n -> data_out = 4'b1010, no rise/fall pulse for 20 cycles.
- data_in[0] 0->1 held (defaults) -> data_out[0] = 1 and rise_pulse[0] = 1 for exactly one cycle at edge 7; other channels unchanged.
- data_in[1] 1-cycle then 3-cycle high glitches (C_FILTER_CYCLES = 4) -> data_out[1] stays 0, no pulses; 4-cycle high -> rise then, 4 cycles after release, fall_pulse[1].
- rst_n asserted while cnt_0 = 2 mid-transition -> all outputs return to C_RVAL/0 asynchronously, no pulse after release.
- Macro defined: transition on channel 2 -> sticky_change[2] = 1 held; clear_sticky[2] pulse -> 0; clear coincident with new transition -> remains 1.
- C_WIDTH = 1, C_NUM_SYNC_REGS = 2, C_FILTER_CYCLES = 1: step input -> data_out changes at edge 3.
